// File: rtl/prci_reset_seq_pkg.sv
// Shared types for the PRCI reset sequencer: FSM states, reset-cause codes,
// the control register set with its reset value, and a counter-width helper.
package prci_reset_seq_pkg;

  typedef enum logic [2:0] {
    S_POR,
    S_WAIT_LOCK,
    S_DBG_HOLD,
    S_SYS_HOLD,
    S_RUN
  } prci_rst_state_t;

  localparam logic [1:0] RST_CAUSE_POR      = 2'd0;
  localparam logic [1:0] RST_CAUSE_LOCKLOSS = 2'd1;
  localparam logic [1:0] RST_CAUSE_WDOG     = 2'd2;
  localparam logic [1:0] RST_CAUSE_SW       = 2'd3;

  typedef struct packed {
    prci_rst_state_t state;
    logic            sys_locked;
    logic            dbg_nrst;
    logic            sys_nrst;
    logic            pcie_nrst;
    logic [1:0]      cause;
  } prci_rst_regs_t;

  localparam prci_rst_regs_t PRCI_RST_REGS_RESET = '{
    state:      S_POR,
    sys_locked: 1'b0,
    dbg_nrst:   1'b0,
    sys_nrst:   1'b0,
    pcie_nrst:  1'b0,
    cause:      RST_CAUSE_POR
  };

  // Wide enough to hold the larger of the two terminal counts.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/prci_sync2.sv
// Two-flop synchronizer for a single asynchronous status bit; clears to 0 in reset.
module prci_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/prci_reset_seq.sv
// Power-on/reset sequencer for the PRCI block: filters PLL lock, releases dbg/sys/PCIe
// resets in order and records the reset cause. Watchdog honoured only with PRCI_RST_SEQ_WDOG_EN.
module prci_reset_seq
  import prci_reset_seq_pkg::*;
#(
  parameter int LOCK_FILTER     = 8,
  parameter int RST_HOLD_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_pll_locked,
  input  logic       i_ddr_calib_done,
  input  logic       i_pcie_lnk_up,
  input  logic       i_sw_sys_rst,
  input  logic       i_wdog_rst,
  output logic       o_sys_rst,
  output logic       o_sys_nrst,
  output logic       o_dbg_nrst,
  output logic       o_pcie_nrst,
  output logic       o_sys_locked,
  output logic       o_ddr_locked,
  output logic       o_pcie_lnk_up,
  output logic [1:0] o_rst_cause
);

  localparam int CW = cnt_width(LOCK_FILTER, RST_HOLD_CYCLES);
  localparam logic [CW-1:0] LOCK_MAX    = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] HOLD_RELOAD = CW'(RST_HOLD_CYCLES - 1);

  logic           pll_sync;
  logic           ddr_sync;
  logic           lnk_sync;
  logic           wdog_req;
  prci_rst_regs_t r;
  prci_rst_regs_t r_nxt;
  logic [CW-1:0]  lock_cnt;
  logic [CW-1:0]  lock_cnt_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;

  prci_sync2 u_sync_pll  (.clk(i_clk), .rst_n(i_nrst), .d(i_pll_locked),     .q(pll_sync));
  prci_sync2 u_sync_ddr  (.clk(i_clk), .rst_n(i_nrst), .d(i_ddr_calib_done), .q(ddr_sync));
  prci_sync2 u_sync_pcie (.clk(i_clk), .rst_n(i_nrst), .d(i_pcie_lnk_up),    .q(lnk_sync));

`ifdef PRCI_RST_SEQ_WDOG_EN
  assign wdog_req = i_wdog_rst;
`else
  logic unused_wdog;
  assign unused_wdog = i_wdog_rst;
  assign wdog_req    = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r        <= PRCI_RST_REGS_RESET;
      lock_cnt <= '0;
      cnt      <= '0;
    end else begin
      r        <= r_nxt;
      lock_cnt <= lock_cnt_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    r_nxt        = r;
    lock_cnt_nxt = lock_cnt;
    cnt_nxt      = cnt;
    case (r.state)
      S_POR: r_nxt.state = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (!pll_sync) begin
          lock_cnt_nxt = '0;
        end else if (lock_cnt >= LOCK_LAST) begin
          lock_cnt_nxt     = LOCK_MAX;
          r_nxt.sys_locked = 1'b1;
          cnt_nxt          = HOLD_RELOAD;
          r_nxt.state      = S_DBG_HOLD;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
      S_DBG_HOLD, S_SYS_HOLD, S_RUN: begin
        // Lock loss outranks every request and tears down all domains, debug included.
        if (!pll_sync) begin
          r_nxt.state      = S_WAIT_LOCK;
          r_nxt.sys_locked = 1'b0;
          r_nxt.dbg_nrst   = 1'b0;
          r_nxt.sys_nrst   = 1'b0;
          r_nxt.pcie_nrst  = 1'b0;
          r_nxt.cause      = RST_CAUSE_LOCKLOSS;
          lock_cnt_nxt     = '0;
        end else if (r.state == S_RUN) begin
          if (wdog_req || i_sw_sys_rst) begin
            r_nxt.state     = S_SYS_HOLD;
            r_nxt.sys_nrst  = 1'b0;
            r_nxt.pcie_nrst = 1'b0;
            r_nxt.cause     = wdog_req ? RST_CAUSE_WDOG : RST_CAUSE_SW;
            cnt_nxt         = HOLD_RELOAD;
          end else begin
            r_nxt.pcie_nrst = 1'b1;
          end
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (r.state == S_DBG_HOLD) begin
          r_nxt.dbg_nrst = 1'b1;
          cnt_nxt        = HOLD_RELOAD;
          r_nxt.state    = S_SYS_HOLD;
        end else begin
          r_nxt.sys_nrst = 1'b1;
          r_nxt.state    = S_RUN;
        end
      end
      default: r_nxt = PRCI_RST_REGS_RESET;
    endcase
  end

  assign o_sys_rst     = ~r.sys_nrst;
  assign o_sys_nrst    = r.sys_nrst;
  assign o_dbg_nrst    = r.dbg_nrst;
  assign o_pcie_nrst   = r.pcie_nrst;
  assign o_sys_locked  = r.sys_locked;
  assign o_ddr_locked  = ddr_sync;
  assign o_pcie_lnk_up = lnk_sync & r.pcie_nrst;
  assign o_rst_cause   = r.cause;

endmodule

// File: tb/tb_prci_reset_seq.sv
// Self-checking bench for prci_reset_seq: timeline-based reference model driven by
// randomized status inputs and request pulses. Honours PRCI_RST_SEQ_WDOG_EN.
`timescale 1ns/1ps
module tb_prci_reset_seq;

  localparam int LF = 8;
  localparam int H  = 16;
`ifdef PRCI_RST_SEQ_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  logic       clk  = 1'b0;
  logic       nrst = 1'b1;
  logic       pll  = 1'b0;
  logic       ddr  = 1'b0;
  logic       lnk  = 1'b0;
  logic       sw   = 1'b0;
  logic       wdog = 1'b0;
  logic       sys_rst, sys_nrst, dbg_nrst, pcie_nrst, sys_locked, ddr_locked, pcie_lnk_up;
  logic [1:0] rst_cause;

  int errors = 0;
  int checks = 0;

  // Reference model: release times are scheduled as absolute edge numbers.
  int         m_n;
  bit         m_locked;
  int         m_run;
  int         m_dbg_at, m_sys_at, m_pcie_at;
  logic [1:0] m_cause;
  bit   [1:0] pll_hist, ddr_hist, lnk_hist;

  always #5 clk = ~clk;

  prci_reset_seq dut (
    .i_clk(clk), .i_nrst(nrst), .i_pll_locked(pll), .i_ddr_calib_done(ddr),
    .i_pcie_lnk_up(lnk), .i_sw_sys_rst(sw), .i_wdog_rst(wdog),
    .o_sys_rst(sys_rst), .o_sys_nrst(sys_nrst), .o_dbg_nrst(dbg_nrst),
    .o_pcie_nrst(pcie_nrst), .o_sys_locked(sys_locked), .o_ddr_locked(ddr_locked),
    .o_pcie_lnk_up(pcie_lnk_up), .o_rst_cause(rst_cause)
  );

  task automatic model_reset();
    m_n = 0; m_locked = 0; m_run = 0;
    m_dbg_at = 0; m_sys_at = 0; m_pcie_at = 0;
    m_cause = 2'd0;
    pll_hist = '0; ddr_hist = '0; lnk_hist = '0;
  endtask

  task automatic model_edge();
    bit s;
    bit in_run;
    m_n++;
    s      = pll_hist[1];
    in_run = m_locked && (m_n - 1 >= m_sys_at);
    if (m_n == 1) begin
    end else if (!m_locked) begin
      if (s) begin
        m_run++;
        if (m_run == LF) begin
          m_locked  = 1;
          m_dbg_at  = m_n + H;
          m_sys_at  = m_n + 2 * H;
          m_pcie_at = m_n + 2 * H + 1;
        end
      end else begin
        m_run = 0;
      end
    end else if (!s) begin
      m_locked = 0; m_run = 0; m_cause = 2'd1;
    end else if (in_run && WDOG_EN && wdog) begin
      m_sys_at = m_n + H; m_pcie_at = m_n + H + 1; m_cause = 2'd2;
    end else if (in_run && sw) begin
      m_sys_at = m_n + H; m_pcie_at = m_n + H + 1; m_cause = 2'd3;
    end
    pll_hist = {pll_hist[0], pll};
    ddr_hist = {ddr_hist[0], ddr};
    lnk_hist = {lnk_hist[0], lnk};
  endtask

  function automatic logic [8:0] exp_vec();
    logic sn, dn, pn;
    dn = m_locked && (m_n >= m_dbg_at);
    sn = m_locked && (m_n >= m_sys_at);
    pn = m_locked && (m_n >= m_pcie_at);
    return {~sn, sn, dn, pn, logic'(m_locked), logic'(ddr_hist[1]), logic'(lnk_hist[1]) & pn, m_cause};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {sys_rst, sys_nrst, dbg_nrst, pcie_nrst, sys_locked, ddr_locked, pcie_lnk_up, rst_cause};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic noise();
    ddr = 1'($urandom_range(0, 1));
    lnk = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_por();
    @(posedge clk); #1;
    nrst = 1'b0; sw = 1'b0; wdog = 1'b0;
    model_reset();
    @(posedge clk); #1;
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    #1 nrst = 1'b0;
    model_reset();
    #2;
    checks++;
    if (dut_vec() !== 9'b1_0000_0000) begin
      errors++; $display("[TB] FAIL reset_async: got %b want %b", dut_vec(), 9'b1_0000_0000);
    end
    for (int i = 0; i < 3; i++) begin
      noise(); pll = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut_vec() !== 9'b1_0000_0000) begin
        errors++; $display("[TB] FAIL reset_hold: got %b want %b", dut_vec(), 9'b1_0000_0000);
      end
    end
  endtask

  task automatic test_power_up();
    apply_por();
    pll = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      noise(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL power_up_model edge %0d: got %b want %b", e, dut_vec(), exp_vec());
      end
      if (e == 9 || e == 10) begin
        checks++;
        if (sys_locked !== (e == 10)) begin
          errors++; $display("[TB] FAIL power_up_locked edge %0d: got %b want %b", e, sys_locked, e == 10);
        end
      end
      if (e == 25 || e == 26) begin
        checks++;
        if (dbg_nrst !== (e == 26)) begin
          errors++; $display("[TB] FAIL power_up_dbg edge %0d: got %b want %b", e, dbg_nrst, e == 26);
        end
      end
      if (e == 41 || e == 42) begin
        checks++;
        if ({sys_nrst, sys_rst} !== ((e == 42) ? 2'b10 : 2'b01)) begin
          errors++; $display("[TB] FAIL power_up_sys edge %0d: got %b%b", e, sys_nrst, sys_rst);
        end
      end
      if (e == 42 || e == 43) begin
        checks++;
        if (pcie_nrst !== (e == 43)) begin
          errors++; $display("[TB] FAIL power_up_pcie edge %0d: got %b want %b", e, pcie_nrst, e == 43);
        end
      end
    end
    checks++;
    if (rst_cause !== 2'd0) begin
      errors++; $display("[TB] FAIL power_up_cause: got %0d want 0", rst_cause);
    end
  endtask

  task automatic test_lock_glitch();
    apply_por();
    for (int e = 1; e <= 20; e++) begin
      pll = (e != 6);
      noise(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL glitch_model edge %0d: got %b want %b", e, dut_vec(), exp_vec());
      end
      if (e == 10 || e == 15 || e == 16) begin
        checks++;
        if (sys_locked !== (e == 16)) begin
          errors++; $display("[TB] FAIL glitch_locked edge %0d: got %b want %b", e, sys_locked, e == 16);
        end
      end
    end
  endtask

  task automatic test_lock_loss();
    int extra;
    apply_por();
    pll = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      noise(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL lockloss_pre edge %0d: got %b want %b", e, dut_vec(), exp_vec());
      end
    end
    pll = 1'b0;
    repeat (3) begin noise(); step(); end
    checks++;
    if ({dbg_nrst, sys_nrst, pcie_nrst, sys_locked, sys_rst, rst_cause} !== 7'b0000_1_01) begin
      errors++;
      $display("[TB] FAIL lockloss_drop: got dbg=%b sys=%b pcie=%b lock=%b rst=%b cause=%0d want 0 0 0 0 1 1",
               dbg_nrst, sys_nrst, pcie_nrst, sys_locked, sys_rst, rst_cause);
    end
    extra = $urandom_range(0, 4);
    for (int i = 0; i < extra; i++) begin noise(); step(); end
    pll = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      noise(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL lockloss_reseq edge %0d: got %b want %b", e, dut_vec(), exp_vec());
      end
    end
    checks++;
    if ({sys_nrst, pcie_nrst, dbg_nrst, rst_cause} !== 5'b111_01) begin
      errors++; $display("[TB] FAIL lockloss_final: got sys=%b pcie=%b dbg=%b cause=%0d want 1 1 1 1",
                         sys_nrst, pcie_nrst, dbg_nrst, rst_cause);
    end
  endtask

  task automatic test_sw_reset();
    sw = 1'b1; noise(); step(); sw = 1'b0;
    checks++;
    if ({sys_nrst, pcie_nrst, dbg_nrst, rst_cause} !== 5'b001_11) begin
      errors++; $display("[TB] FAIL sw_enter: got sys=%b pcie=%b dbg=%b cause=%0d want 0 0 1 3",
                         sys_nrst, pcie_nrst, dbg_nrst, rst_cause);
    end
    for (int k = 1; k <= 18; k++) begin
      noise(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL sw_model step %0d: got %b want %b", k, dut_vec(), exp_vec());
      end
      if (k == 15 || k == 16) begin
        checks++;
        if (sys_nrst !== (k == 16)) begin
          errors++; $display("[TB] FAIL sw_release step %0d: got %b want %b", k, sys_nrst, k == 16);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [1:0] want;
    want = WDOG_EN ? 2'd2 : 2'd3;
    sw = 1'b1; wdog = 1'b1; noise(); step(); sw = 1'b0; wdog = 1'b0;
    checks++;
    if (rst_cause !== want || sys_nrst !== 1'b0 || dbg_nrst !== 1'b1) begin
      errors++; $display("[TB] FAIL priority_cause: got cause=%0d sys=%b dbg=%b want cause=%0d 0 1",
                         rst_cause, sys_nrst, dbg_nrst, want);
    end
    apply_por();
    pll = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      sw = (e == 15);
      noise(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL sw_in_dbg edge %0d: got %b want %b", e, dut_vec(), exp_vec());
      end
    end
    sw = 1'b0;
    checks++;
    if ({sys_nrst, pcie_nrst, rst_cause} !== 4'b11_00) begin
      errors++; $display("[TB] FAIL sw_in_dbg_final: got sys=%b pcie=%b cause=%0d want 1 1 0",
                         sys_nrst, pcie_nrst, rst_cause);
    end
  endtask

  task automatic test_async_reset();
    apply_por();
    pll = 1'b1;
    for (int e = 1; e <= 30; e++) begin noise(); step(); end
    #2 nrst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 9'b1_0000_0000) begin
      errors++; $display("[TB] FAIL async_mid_hold: got %b want %b", dut_vec(), 9'b1_0000_0000);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int e = 1; e <= 45; e++) begin
      noise(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL async_restart edge %0d: got %b want %b", e, dut_vec(), exp_vec());
      end
      if (e == 42 || e == 43) begin
        checks++;
        if ({sys_nrst, pcie_nrst} !== ((e == 42) ? 2'b10 : 2'b11)) begin
          errors++; $display("[TB] FAIL async_release edge %0d: got %b%b", e, sys_nrst, pcie_nrst);
        end
      end
    end
  endtask

  task automatic test_random();
    int low_left;
    low_left = 0;
    apply_por();
    for (int e = 1; e <= 800; e++) begin
      if (low_left > 0) begin
        pll = 1'b0; low_left--;
      end else begin
        pll = 1'b1;
        if ($urandom_range(0, 59) == 0) low_left = $urandom_range(1, 4);
      end
      sw   = ($urandom_range(0, 19) == 0);
      wdog = ($urandom_range(0, 19) == 0);
      noise(); step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("[TB] FAIL random edge %0d: got %b want %b", e, dut_vec(), exp_vec());
      end
    end
    sw = 1'b0; wdog = 1'b0;
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_lock_loss();
    test_sw_reset();
    test_priority();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
